pipeline_fetch_unit: RTL and testbench

//  IF stage of the 5-stage RV32 pipeline. Owns the PC, issues word fetches to instruction memory, and registers
//  {instruction, pc, valid} into the IF/ID boundary consumed by the decode stage. Handles decode stalls and

---
 rtl/pipeline_fetch_unit.sv | 137 +++++++++++++
 tb/tb_pipeline_fetch_unit.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_fetch_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------------------+
// | pipeline_fetch_unit : RV32 IF stage - PC, single-outstanding imem fetch, IF/ID slot  |
// | Rev 1.0                                                                               |
// +--------------------------------------------------------------------------------------+
module pipeline_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] instruction_o,
  output logic [31:0] pc_o,
  output logic        valid_o
);

  typedef enum logic [1:0] {
    S_ISSUE = 2'd0,
    S_WAIT  = 2'd1,
    S_DROP  = 2'd2,
    S_HOLD  = 2'd3
  } state_e;

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] fpc_q;
  logic [31:0] skid_instr_q;
  logic [31:0] skid_pc_q;
  logic [31:0] instr_q;
  logic [31:0] pco_q;
  logic        valid_q;

  logic [31:0] redirect_tgt;
  logic [31:0] fpc_next;
  logic        slot_free;
  logic        load_resp;
  logic        load_skid;

  assign redirect_tgt = redirect_pc_i & ~32'h3;
  assign fpc_next     = fpc_q + 32'd4;
  // An empty slot may fill even while decode is stalled.
  assign slot_free    = !valid_q || !stall_i;
  assign load_resp    = (state_q == S_WAIT) && imem_rvalid_i && slot_free;
  assign load_skid    = (state_q == S_HOLD) && slot_free;

  assign imem_req_o    = (state_q == S_ISSUE) && !rst_i;
  assign imem_addr_o   = pc_q;
  assign instruction_o = instr_q;
  assign pc_o          = pco_q;
  assign valid_o       = valid_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= S_ISSUE;
      pc_q         <= RESET_PC;
      fpc_q        <= RESET_PC;
      skid_instr_q <= NOP_INSTR;
      skid_pc_q    <= RESET_PC;
      instr_q      <= NOP_INSTR;
      pco_q        <= RESET_PC;
      valid_q      <= 1'b0;
    end else begin
      // Redirect wins over stall and over any same-cycle response.
      if (redirect_i) begin
        instr_q <= NOP_INSTR;
        valid_q <= 1'b0;
      end else if (load_resp) begin
        instr_q <= imem_rdata_i;
        pco_q   <= fpc_q;
        valid_q <= 1'b1;
      end else if (load_skid) begin
        instr_q <= skid_instr_q;
        pco_q   <= skid_pc_q;
        valid_q <= 1'b1;
      end else if (valid_q && !stall_i) begin
        instr_q <= NOP_INSTR;
        valid_q <= 1'b0;
      end

      if (redirect_i) begin
        pc_q <= redirect_tgt;
      end

      case (state_q)
        S_ISSUE: begin
          if (imem_gnt_i) begin
            if (redirect_i) begin
              state_q <= S_DROP;
            end else begin
              state_q <= S_WAIT;
              fpc_q   <= pc_q;
            end
          end
        end
        S_WAIT: begin
          if (redirect_i) begin
            state_q <= imem_rvalid_i ? S_ISSUE : S_DROP;
          end else if (imem_rvalid_i) begin
            pc_q <= fpc_next;
            if (slot_free) begin
              state_q <= S_ISSUE;
            end else begin
              state_q      <= S_HOLD;
              skid_instr_q <= imem_rdata_i;
              skid_pc_q    <= fpc_q;
            end
          end
        end
        S_DROP: begin
          if (imem_rvalid_i) begin
            state_q <= S_ISSUE;
          end
        end
        S_HOLD: begin
          if (redirect_i) begin
            state_q      <= S_ISSUE;
            skid_instr_q <= NOP_INSTR;
            skid_pc_q    <= RESET_PC;
          end else if (slot_free) begin
            state_q <= S_ISSUE;
          end
        end
        default: state_q <= S_ISSUE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pipeline_fetch_unit.sv
`default_nettype none
// Bench for pipeline_fetch_unit: two instances (default and wrap-around RESET_PC) share stimulus,
// compared every cycle against a request/response-level model, plus hand-computed literal checks.
module tb_pipeline_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] RPC_A = 32'h0000_0000;
  localparam logic [31:0] RPC_B = 32'hFFFF_FFFC;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        stall_i = 1'b0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic        imem_gnt_i = 1'b0;
  logic        imem_rvalid_i = 1'b0;
  logic [31:0] imem_rdata_i = '0;

  logic        req   [2];
  logic [31:0] addr  [2];
  logic [31:0] instr [2];
  logic [31:0] pco   [2];
  logic        valid [2];

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  pipeline_fetch_unit #(.RESET_PC(RPC_A), .NOP_INSTR(NOP)) dut_a (
    .clk_i(clk), .rst_i(rst_i), .stall_i(stall_i), .redirect_i(redirect_i),
    .redirect_pc_i(redirect_pc_i), .imem_req_o(req[0]), .imem_addr_o(addr[0]),
    .imem_gnt_i(imem_gnt_i), .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
    .instruction_o(instr[0]), .pc_o(pco[0]), .valid_o(valid[0])
  );

  pipeline_fetch_unit #(.RESET_PC(RPC_B), .NOP_INSTR(NOP)) dut_b (
    .clk_i(clk), .rst_i(rst_i), .stall_i(stall_i), .redirect_i(redirect_i),
    .redirect_pc_i(redirect_pc_i), .imem_req_o(req[1]), .imem_addr_o(addr[1]),
    .imem_gnt_i(imem_gnt_i), .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
    .instruction_o(instr[1]), .pc_o(pco[1]), .valid_o(valid[1])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Model: next fetch pc, one outstanding request (possibly doomed by a redirect),
  // one parked word waiting for the slot, and the IF/ID slot itself.
  logic [31:0] m_pc [2], m_out_pc [2], m_buf_i [2], m_buf_pc [2], m_instr [2], m_pco [2];
  bit          m_out [2], m_dead [2], m_buf_v [2], m_valid [2];

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst_i) begin
        m_pc[k] = (k == 0) ? RPC_A : RPC_B;
        m_pco[k] = m_pc[k];
        m_instr[k] = NOP;
        m_valid[k] = 0; m_out[k] = 0; m_dead[k] = 0; m_buf_v[k] = 0;
        m_out_pc[k] = 0; m_buf_i[k] = 0; m_buf_pc[k] = 0;
      end else begin
        bit fire, resp, have, free;
        logic [31:0] w_i, w_pc;
        fire = !m_out[k] && !m_buf_v[k] && imem_gnt_i;
        resp = m_out[k] && imem_rvalid_i;
        have = 0; w_i = 0; w_pc = 0;
        if (redirect_i) begin
          m_pc[k] = {redirect_pc_i[31:2], 2'b00};
          m_valid[k] = 0; m_instr[k] = NOP; m_buf_v[k] = 0;
          if (fire) begin m_out[k] = 1; m_dead[k] = 1; end
          else if (resp) m_out[k] = 0;
          else if (m_out[k]) m_dead[k] = 1;
        end else begin
          if (resp) begin
            m_out[k] = 0;
            if (!m_dead[k]) begin
              have = 1; w_i = imem_rdata_i; w_pc = m_out_pc[k]; m_pc[k] = m_out_pc[k] + 4;
            end
          end
          if (fire) begin m_out[k] = 1; m_dead[k] = 0; m_out_pc[k] = m_pc[k]; end
          free = !m_valid[k] || !stall_i;
          if (have) begin
            if (free) begin m_instr[k] = w_i; m_pco[k] = w_pc; m_valid[k] = 1; end
            else begin m_buf_v[k] = 1; m_buf_i[k] = w_i; m_buf_pc[k] = w_pc; end
          end else if (m_buf_v[k] && free) begin
            m_instr[k] = m_buf_i[k]; m_pco[k] = m_buf_pc[k]; m_valid[k] = 1; m_buf_v[k] = 0;
          end else if (m_valid[k] && !stall_i) begin
            m_valid[k] = 0; m_instr[k] = NOP;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        bit ereq;
        ereq = !rst_i && !m_out[k] && !m_buf_v[k];
        chk($sformatf("req[%0d]", k), {31'd0, req[k]}, {31'd0, ereq});
        if (ereq) chk($sformatf("addr[%0d]", k), addr[k], m_pc[k]);
        chk($sformatf("valid[%0d]", k), {31'd0, valid[k]}, {31'd0, m_valid[k]});
        chk($sformatf("instr[%0d]", k), instr[k], m_instr[k]);
        chk($sformatf("pc_o[%0d]", k), pco[k], m_pco[k]);
      end
    end
  end

  task automatic cyc(input logic g, input logic rv, input logic [31:0] rd,
                     input logic st, input logic rdr, input logic [31:0] rp);
    imem_gnt_i = g; imem_rvalid_i = rv; imem_rdata_i = rd;
    stall_i = st; redirect_i = rdr; redirect_pc_i = rp;
    @(posedge clk); #1;
    imem_gnt_i = 0; imem_rvalid_i = 0; redirect_i = 0;
  endtask

  initial begin
    cyc(0, 0, 0, 0, 0, 0);
    chk_en = 1;
    cyc(0, 0, 0, 0, 0, 0);
    chk("rst_valid", {31'd0, valid[0]}, 32'd0);
    chk("rst_instr", instr[0], NOP);
    chk("rst_pc_a", pco[0], 32'h0);
    chk("rst_pc_b", pco[1], 32'hFFFF_FFFC);
    chk("rst_req_low", {31'd0, req[0]}, 32'd0);
    rst_i = 0; #1;
    chk("first_req", {31'd0, req[0]}, 32'd1);
    chk("first_addr_a", addr[0], 32'h0);
    chk("first_addr_b", addr[1], 32'hFFFF_FFFC);

    // zero-wait fetches
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 1, 32'h0050_0093, 0, 0, 0);
    chk("t1_valid", {31'd0, valid[0]}, 32'd1);
    chk("t1_pc", pco[0], 32'h0);
    chk("t1_instr", instr[0], 32'h0050_0093);
    chk("t1_addr4", addr[0], 32'h4);
    chk("t1_b_pc", pco[1], 32'hFFFF_FFFC);
    chk("t1_b_wrap", addr[1], 32'h0);
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 1, 32'h00A0_0113, 0, 0, 0);
    chk("t1_pc4", pco[0], 32'h4);
    chk("t1_addr8", addr[0], 32'h8);

    // grant withheld
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 0, 0, 0);
      chk("t2_req", {31'd0, req[0]}, 32'd1);
      chk("t2_addr", addr[0], 32'h8);
    end
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 1, 32'h0010_8093, 0, 0, 0);

    // stall with full slot parks the response
    cyc(1, 0, 0, 1, 0, 0);
    cyc(0, 1, 32'h0020_8113, 1, 0, 0);
    chk("t3_req0", {31'd0, req[0]}, 32'd0);
    chk("t3_hold_pc", pco[0], 32'h8);
    chk("t3_hold_instr", instr[0], 32'h0010_8093);
    cyc(0, 0, 0, 1, 0, 0);
    chk("t3_still_req0", {31'd0, req[0]}, 32'd0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("t3_buf_instr", instr[0], 32'h0020_8113);
    chk("t3_buf_pc", pco[0], 32'hC);
    chk("t3_resume", addr[0], 32'h10);

    // redirect while waiting; stale response dropped
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 32'h100);
    chk("t4_valid0", {31'd0, valid[0]}, 32'd0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 1, 32'hDEAD_BEEF, 0, 0, 0);
    chk("t4_nop", instr[0], NOP);
    chk("t4_addr", addr[0], 32'h100);
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 1, 32'h0031_0193, 0, 0, 0);
    chk("t4_pc", pco[0], 32'h100);

    // redirect + rvalid + stall together, unaligned target
    cyc(1, 0, 0, 1, 0, 0);
    cyc(0, 1, 32'hBAD0_0001, 1, 1, 32'h203);
    chk("t5_valid0", {31'd0, valid[0]}, 32'd0);
    chk("t5_pc_kept", pco[0], 32'h100);
    chk("t5_addr", addr[0], 32'h200);

    // empty slot fills despite stall
    cyc(1, 0, 0, 1, 0, 0);
    cyc(0, 1, 32'h0040_0213, 1, 0, 0);
    chk("es_valid", {31'd0, valid[0]}, 32'd1);
    chk("es_pc", pco[0], 32'h200);

    // wrap through redirect in ISSUE without grant
    cyc(0, 0, 0, 0, 1, 32'hFFFF_FFFF);
    chk("wr_addr", addr[0], 32'hFFFF_FFFC);
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 1, 32'h0050_0293, 0, 0, 0);
    chk("wr_pc", pco[0], 32'hFFFF_FFFC);
    chk("wr_next", addr[0], 32'h0);

    // grant+redirect in ISSUE, then redirect during drop
    cyc(1, 0, 0, 0, 1, 32'h40);
    chk("dr_req0", {31'd0, req[0]}, 32'd0);
    cyc(0, 0, 0, 0, 1, 32'h80);
    cyc(0, 1, 32'hBAD0_0002, 0, 0, 0);
    chk("dr_addr", addr[0], 32'h80);
    chk("dr_nop", instr[0], NOP);

    // redirect while holding a parked word
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 1, 32'h0060_0313, 0, 0, 0);
    cyc(1, 0, 0, 1, 0, 0);
    cyc(0, 1, 32'h0070_0393, 1, 0, 0);
    cyc(0, 0, 0, 1, 1, 32'h300);
    chk("hr_valid0", {31'd0, valid[0]}, 32'd0);
    chk("hr_addr", addr[0], 32'h300);
    chk("hr_pc_kept", pco[0], 32'h80);
    cyc(0, 0, 0, 0, 0, 0);
    chk("hr_no_reload", {31'd0, valid[0]}, 32'd0);

    // reset while waiting
    cyc(1, 0, 0, 0, 0, 0);
    rst_i = 1;
    cyc(0, 0, 0, 0, 0, 0);
    chk("mr_valid0", {31'd0, valid[0]}, 32'd0);
    chk("mr_req0", {31'd0, req[0]}, 32'd0);
    rst_i = 0; #1;
    chk("mr_addr_a", addr[0], 32'h0);
    chk("mr_addr_b", addr[1], 32'hFFFF_FFFC);
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 1, 32'h0080_0413, 0, 0, 0);
    chk("mr_fetch", instr[0], 32'h0080_0413);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
